sbase_step_timer: RTL and testbench
===================================

Name: sbase_step_timer

Overview:
- Responder end of the sequencer step handshake: accepts the one-cycle step-trigger pulse plus the sequencer's one-hot state vector, and times a per-state programmable dwell.
- Drives a busy level (POUT) back to the sequencer's ready input (inverted there) and a one-cycle completion pulse (POUT_ONE).
- Replaces a single fixed-length timer when each of the four sequencer states needs its own dwell time.
- Sits between the 4-state sequencer and the LED/actuator outputs in the step-sequencer top levels.

Parameters:
- CNT_W, 24, dwell counter width in bits.
- T0, 24'd12000000, dwell for STATE[0] in CLK cycles.
- T1, 24'd6000000, dwell for STATE[1] in CLK cycles.
- T2, 24'd3000000, dwell for STATE[2] in CLK cycles.
- T3, 24'd1500000, dwell for STATE[3] in CLK cycles.
- A parameter value of 0 is treated as 1.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- R  in  1  reset, synchronous, active-high.
- TRG_ONE  in  1  one-cycle start request from the sequencer.
- STATE  in  4  one-hot sequencer state; selects the dwell time.
- MODE  in  1  0 = ignore triggers while busy; 1 = retrigger restarts the dwell.
- POUT  out  1  busy; high for exactly the selected dwell length.
- POUT_ONE  out  1  one-cycle pulse on the cycle after POUT falls.
- SEL  out  2  binary index of the dwell currently or last accepted.
- ERR  out  1  sticky flag: a trigger arrived with a STATE that was not one-hot.

Behaviour:
- Reset: when R=1 at an edge, POUT=0, POUT_ONE=0, SEL=0, ERR=0 and the counter is cleared. R takes priority over every other input, including mid-dwell; no POUT_ONE is produced for an aborted dwell.
- States:
  - IDLE (POUT=0).
  - RUN (POUT=1).
  - POUT_ONE is a registered pulse asserted on the RUN->IDLE transition.
- Trigger acceptance: a trigger is accepted when TRG_ONE=1, STATE is exactly one-hot, and either POUT=0 or MODE=1.
- On an accepted trigger at edge k:
  - POUT=1 from edge k.
  - The counter loads Tsel-1, where Tsel is the clamped dwell for the selected state.
  - SEL is set to the index of the set STATE bit.
  - POUT_ONE is 0 at edge k.
- While in RUN, at each edge with no accepted trigger:
  - If the counter is 0: POUT<=0 and POUT_ONE<=1.
  - Otherwise: decrement the counter and POUT_ONE<=0.
- Timing:
  - POUT is high for exactly Tsel cycles.
  - POUT_ONE is high for exactly one cycle, starting at edge k+Tsel.
  - Latency from TRG_ONE to POUT rising is one edge.
- Non-one-hot STATE with TRG_ONE=1 (0000 or two or more bits set): ERR<=1, the trigger is ignored, and all other state is unchanged. ERR clears only on R.
- Retrigger while busy:
  - MODE=0: the trigger is ignored and the dwell continues. This is not an error.
  - MODE=1: the counter reloads from the new STATE and SEL updates.
  - If the retrigger lands on the terminal edge (counter=0), the restart wins: POUT stays 1 and no POUT_ONE is produced.
- Trigger on the edge where POUT_ONE=1: POUT is already 0, so the trigger is accepted normally. POUT_ONE and POUT can then both be 1 in the same cycle; this is legal.
- TRG_ONE held high across many cycles:
  - MODE=0: only the first edge is accepted.
  - MODE=1: every edge restarts the dwell. Callers must supply single-cycle pulses.
- Width rules:
  - Tsel is truncated to CNT_W bits.
  - The counter never wraps, because the decrement is blocked at 0.
- STATE changes during RUN do not affect the dwell in progress (the dwell length is latched at acceptance).

Test Plan:
- Reset and defaults (T0..T3 overridden to 5,3,1,0): assert R for 2 cycles -> POUT=0, POUT_ONE=0, SEL=0, ERR=0.
- Per-state dwell:
  - STATE=0001 with TRG_ONE -> POUT high for 5 cycles, then POUT_ONE for 1 cycle, SEL=0.
  - STATE=0010 -> POUT high 3 cycles, SEL=1.
  - STATE=0100 -> POUT high 1 cycle.
  - STATE=1000 (T3=0 clamped) -> POUT high 1 cycle.
- MODE=0 retrigger: STATE=0001 trigger, then another trigger 2 cycles later -> POUT still high exactly 5 cycles from the first trigger, one POUT_ONE, ERR=0.
- MODE=1 retrigger, two cases:
  - STATE=0001 trigger, then STATE=0010 trigger 2 cycles later -> POUT high 2+3=5 cycles total, SEL=1.
  - A retrigger on the terminal edge -> no POUT_ONE, POUT stays high.
- Error and reset mid-dwell:
  - TRG_ONE with STATE=0011 -> ERR=1, POUT stays 0.
  - A later STATE=0001 trigger runs normally and ERR stays 1.
  - R asserted at dwell cycle 2 -> POUT=0, ERR=0, and no POUT_ONE for the aborted dwell.
- Back-to-back handshake: a trigger on the POUT_ONE cycle -> the new dwell starts on the next edge with no idle gap; a closed-loop run against the 4-state sequencer steps 0->1->2->3->0 with LED dwells of 5,3,1,1 cycles.

Source files
------------

// File: rtl/sbase_step_timer.sv
// sbase_step_timer
// Responder end of the sequencer step handshake. A one-cycle trigger together
// with a one-hot sequencer state starts a dwell whose length depends on the
// state. The busy level is high for exactly the selected dwell. A one-cycle
// done pulse follows on the cycle after busy falls.
//
// Ports
//   CLK       in   system clock, rising edge
//   R         in   synchronous active-high reset, highest priority
//   TRG_ONE   in   one-cycle start request
//   STATE     in   [3:0] one-hot sequencer state, selects the dwell
//   MODE      in   0: ignore triggers while busy, 1: retrigger restarts dwell
//   POUT      out  busy, high for exactly the selected dwell length
//   POUT_ONE  out  one-cycle pulse on the cycle after POUT falls
//   SEL       out  [1:0] index of the dwell currently or last accepted
//   ERR       out  sticky: a trigger arrived with a non-one-hot STATE
module sbase_step_timer #(
  parameter int unsigned CNT_W = 24,
  parameter int unsigned T0    = 12000000,
  parameter int unsigned T1    = 6000000,
  parameter int unsigned T2    = 3000000,
  parameter int unsigned T3    = 1500000
) (
  input  logic       CLK,
  input  logic       R,
  input  logic       TRG_ONE,
  input  logic [3:0] STATE,
  input  logic       MODE,
  output logic       POUT,
  output logic       POUT_ONE,
  output logic [1:0] SEL,
  output logic       ERR
);

  localparam logic [CNT_W-1:0] One = CNT_W'(1);

  // Truncate to the counter width, then treat 0 as 1. The result is the
  // value loaded into the counter (dwell minus one).
  function automatic logic [CNT_W-1:0] load_val(input int unsigned t);
    logic [CNT_W-1:0] v;
    v = CNT_W'(t);
    if (v == '0) begin
      v = One;
    end
    return v - One;
  endfunction

  localparam logic [CNT_W-1:0] Load0 = load_val(T0);
  localparam logic [CNT_W-1:0] Load1 = load_val(T1);
  localparam logic [CNT_W-1:0] Load2 = load_val(T2);
  localparam logic [CNT_W-1:0] Load3 = load_val(T3);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             err_q, err_d;
  logic             pone_q, pone_d;

  logic             onehot;
  logic             accept;
  logic [1:0]       idx;
  logic [CNT_W-1:0] load;

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
  assign onehot = (STATE != 4'b0000) && ((STATE & (STATE - 4'd1)) == 4'b0000);
  assign accept = TRG_ONE && onehot && ((state_q == StIdle) || MODE);

  always_comb begin
    idx  = 2'd0;
    load = Load0;
    case (STATE)
      4'b0001: begin idx = 2'd0; load = Load0; end
      4'b0010: begin idx = 2'd1; load = Load1; end
      4'b0100: begin idx = 2'd2; load = Load2; end
      4'b1000: begin idx = 2'd3; load = Load3; end
      default: begin idx = 2'd0; load = Load0; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    err_d   = err_q;
    pone_d  = 1'b0;

    if (TRG_ONE && !onehot) begin
      err_d = 1'b1;
    end

    // An accepted trigger beats the terminal edge, so a retrigger landing
    // on counter=0 keeps the output busy and suppresses the done pulse.
    if (accept) begin
      state_d = StRun;
      cnt_d   = load;
      sel_d   = idx;
    end else if (state_q == StRun) begin
      if (cnt_q == '0) begin
        state_d = StIdle;
        pone_d  = 1'b1;
      end else begin
        cnt_d = cnt_q - One;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (R) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sel_q   <= 2'd0;
      err_q   <= 1'b0;
      pone_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      pone_q  <= pone_d;
    end
  end

  assign POUT     = (state_q == StRun);
  assign POUT_ONE = pone_q;
  assign SEL      = sel_q;
  assign ERR      = err_q;

endmodule

// File: tb/tb_sbase_step_timer.sv
module tb_sbase_step_timer;

  logic       clk = 1'b0;
  logic       r;
  logic       trg;
  logic [3:0] st;
  logic       mode;
  logic       pout;
  logic       pone;
  logic [1:0] sel;
  logic       err;

  sbase_step_timer #(
    .CNT_W(24),
    .T0   (5),
    .T1   (3),
    .T2   (1),
    .T3   (0)
  ) dut (
    .CLK     (clk),
    .R       (r),
    .TRG_ONE (trg),
    .STATE   (st),
    .MODE    (mode),
    .POUT    (pout),
    .POUT_ONE(pone),
    .SEL     (sel),
    .ERR     (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] sel;
    int         len;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cur_len = 0;
  int   last_len = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input logic [1:0] s, input int len, input logic e);
    exp_t x;
    x.sel = s;
    x.len = len;
    x.err = e;
    q.push_back(x);
  endtask

  // Caller sits at a negedge; the trigger is taken on the next rising edge.
  task automatic trig(input logic [3:0] s, input logic m);
    trg  = 1'b1;
    st   = s;
    mode = m;
    @(negedge clk);
    trg = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (pone) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk(name, 0, 1);
  endtask

  // Monitor: measures each busy run and scores it against the queue head
  // whenever the done pulse appears.
  always @(negedge clk) begin
    exp_t e;
    if (r) begin
      cur_len = 0;
    end else if (pout) begin
      cur_len++;
    end else if (cur_len != 0) begin
      last_len = cur_len;
      cur_len  = 0;
    end
    if (pone) begin
      if (q.size() == 0) begin
        chk("spurious_pout_one", 1, 0);
      end else begin
        e = q.pop_front();
        chk("dwell_len", last_len, e.len);
        chk("sel", int'(sel), int'(e.sel));
        chk("err_at_done", int'(err), int'(e.err));
      end
    end
  end

  logic [3:0] loop_st [5];
  int         loop_len[5];

  initial begin
    r    = 1'b1;
    trg  = 1'b0;
    st   = 4'b0000;
    mode = 1'b0;
    idle(2);
    chk("rst_pout", int'(pout), 0);
    chk("rst_pout_one", int'(pone), 0);
    chk("rst_sel", int'(sel), 0);
    chk("rst_err", int'(err), 0);
    r = 1'b0;
    idle(1);

    // Per-state dwells, T3=0 clamped to 1.
    push_exp(2'd0, 5, 1'b0); trig(4'b0001, 1'b0);
    chk("latency_pout", int'(pout), 1);
    idle(8);
    push_exp(2'd1, 3, 1'b0); trig(4'b0010, 1'b0); idle(6);
    push_exp(2'd2, 1, 1'b0); trig(4'b0100, 1'b0); idle(4);
    push_exp(2'd3, 1, 1'b0); trig(4'b1000, 1'b0); idle(4);

    // MODE=0 retrigger ignored.
    push_exp(2'd0, 5, 1'b0); trig(4'b0001, 1'b0); idle(1);
    trig(4'b0010, 1'b0); idle(8);

    // MODE=1 retrigger two cycles in: 2 + 3 cycles, SEL follows.
    push_exp(2'd1, 5, 1'b0); trig(4'b0001, 1'b1); idle(1);
    trig(4'b0010, 1'b1); idle(8);

    // MODE=1 retrigger on the terminal edge: 5 + 3 cycles, no pulse between.
    push_exp(2'd1, 8, 1'b0); trig(4'b0001, 1'b1); idle(4);
    trig(4'b0010, 1'b1);
    chk("terminal_retrig_busy", int'(pout), 1);
    chk("terminal_retrig_no_pulse", int'(pone), 0);
    idle(8);

    // Non-one-hot trigger flags ERR and is ignored.
    trig(4'b0011, 1'b0);
    chk("bad_state_err", int'(err), 1);
    chk("bad_state_pout", int'(pout), 0);
    push_exp(2'd0, 5, 1'b1); trig(4'b0001, 1'b0); idle(8);
    chk("err_sticky", int'(err), 1);

    // Reset mid-dwell: no done pulse for the aborted dwell.
    trig(4'b0001, 1'b0); idle(1);
    r = 1'b1;
    @(negedge clk);
    r = 1'b0;
    chk("mid_rst_pout", int'(pout), 0);
    chk("mid_rst_err", int'(err), 0);
    chk("mid_rst_pout_one", int'(pone), 0);
    idle(8);

    // Trigger on the done-pulse cycle starts the next dwell on the next edge.
    push_exp(2'd1, 3, 1'b0); trig(4'b0010, 1'b0); idle(3);
    chk("b2b_done_cycle", int'(pone), 1);
    push_exp(2'd2, 1, 1'b0); trig(4'b0100, 1'b0);
    chk("b2b_restart", int'(pout), 1);
    idle(5);

    // Closed loop with a 4-state sequencer: step on each done pulse.
    loop_st[0] = 4'b0001; loop_len[0] = 5;
    loop_st[1] = 4'b0010; loop_len[1] = 3;
    loop_st[2] = 4'b0100; loop_len[2] = 1;
    loop_st[3] = 4'b1000; loop_len[3] = 1;
    loop_st[4] = 4'b0001; loop_len[4] = 5;
    for (int i = 0; i < 5; i++) begin
      push_exp(2'(i % 4), loop_len[i], 1'b0);
      trig(loop_st[i], 1'b0);
      wait_done("loop_timeout");
      chk("loop_ready", int'(pout), 0);
    end

    idle(10);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
